board_debug_console: RTL and testbench
======================================

// Module: board_debug_console
// PURPOSE
//  Parametrised board-level run/step controller and result display for the pipelined CPU on DE1-SoC.
//  Generates a clock-enable (not a derived clock) for the CPU core and debounces board push-buttons.
//  Provides RUN / HALT / single-STEP control.
//  Captures the CPU result word and shows a pageable nibble window on N seven-segment digits plus LEDs.
// PARAMETERS
//  DIV          25_000_000  clk cycles per RUN-mode enable pulse (>=2)
//  DEBOUNCE_CYC 500_000     cycles a synced button level must be stable to be accepted (>=1)
//  NUM_DIGITS   2           seven-segment digits driven (1..8)
//  LED_W        10          LEDs driven from result LSBs (1..32)
// PORTS
//  clk          in   1               system clock (50 MHz)
//  rst          in   1               synchronous, active-high reset
//  btn_mode_n   in   1               raw button, active-low: toggle RUN/HALT
//  btn_step_n   in   1               raw button, active-low: single step while halted
//  btn_page_n   in   1               raw button, active-low: advance display page
//  cpu_result   in   32              CPU ALU result
//  cpu_ce       out  1               one-cycle CPU clock-enable pulse
//  mode_led     out  2               {halted, running}
//  ledr         out  LED_W           captured word [LED_W-1:0]
//  hex          out  7*NUM_DIGITS    active-low segments; digit d at [7d+6:7d]
// BEHAVIOUR
//  - Reset values: cpu_ce=0, ledr=0, mode_led=2'b01 (RUN), every digit 7'b1000000 ('0').
//  - Reset clears divider, debouncers, page, captured word and FSM. Reset mid-step drops any pending pulse.
//  - Buttons: 2-flop synchroniser, then debounce counter.
//    - New level accepted after DEBOUNCE_CYC consecutive equal samples; any mismatch restarts the count.
//    - Press = one-cycle pulse on accepted 1->0 transition; releases generate nothing.
//  - Divider: cnt 0..DIV-1, wraps to 0. tick=1 when cnt==DIV-1. Runs in every mode.
//  - FSM {RUN, HALT, STEP}; reset -> RUN.
//    - RUN:  cpu_ce=tick. mode press -> HALT.
//    - HALT: cpu_ce=0. mode press -> RUN; step press (no mode press) -> STEP.
//    - STEP: cpu_ce=1 for exactly this cycle -> HALT.
//    - Simultaneous mode+step press in HALT: mode wins, no step pulse.
//    - Step presses in RUN are ignored.
//  - Capture: cpu_result is sampled into word on the cycle after cpu_ce=1 (post-update value).
//  - Display: ledr/hex are registered from word.
//    - ledr/hex change 2 cycles after the cpu_ce pulse.
//    - PAGES=ceil(8/NUM_DIGITS). Page press: page=(page+1)%PAGES.
//    - Digit d shows nibble n=page*NUM_DIGITS+d. Nibbles with n>7 are blank (7'b1111111).
//  - Hex decode covers 0-F in standard DE1 active-low encoding.
// CONFIGURATION
//  LEADING_ZERO_BLANK_EN defined:
//    - Digits above the most-significant non-zero nibble of the current page are blank.
//    - Digit 0 always shows its value, so word 0 displays '0'.
//  Not defined: all in-range digits always show their value, including leading zeros.
// STRUCTURE
//  - Package board_dbg_pkg:
//    - mode_t enum {RUN, HALT, STEP}
//    - SEG_BLANK = 7'b1111111
//    - 16-entry active-low hex segment table
//    - function pages(NUM_DIGITS)
//  - Sub-module btn_debounce (sync + debounce + press pulse), instantiated 3x.
//  - Hex decode is a package function, not a module.
// TESTING (DIV=4, DEBOUNCE_CYC=3, NUM_DIGITS=2, LED_W=10)
//  - Reset, then RUN: cpu_ce pulses every 4th cycle. After result 32'h0000_00A5: hex1/hex0='A''5', ledr=10'h0A5.
//  - Mode press in RUN: mode_led=2'b10, no cpu_ce for 40 cycles.
//    Step press: exactly one cpu_ce, word captures next cpu_result.
//  - Bounce 1-0-1-0 at 1-cycle spacing, then hold low for 3+ cycles: exactly one press pulse. Release bounce: none.
//  - Simultaneous mode+step press in HALT: mode_led=2'b01, no extra cpu_ce beyond RUN ticks.
//  - word=32'h1234_5678: 4 page presses show 78,56,34,12, then 78 again (wrap).
//    With LEADING_ZERO_BLANK_EN and word=32'h0000_0005: hex1 blank, hex0 '5'.
//  - Assert rst during STEP and during a debounce count: cpu_ce=0 next cycle, all outputs at reset values.

Source files
------------

// File: rtl/board_dbg_pkg.sv
// board_dbg_pkg: shared types, segment table and helpers for the board debug console
package board_dbg_pkg;
  typedef enum logic [1:0] {RUN, HALT, STEP} mode_t;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [15:0][6:0] SEG_TAB = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };
  function automatic int pages(input int num_digits);
    return (8 + num_digits - 1) / num_digits;
  endfunction
  function automatic logic [6:0] hex_seg(input logic [3:0] v);
    return SEG_TAB[v];
  endfunction
endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: 2-flop synchroniser, level debouncer and one-cycle press pulse
// Ports: clk, rst (sync, active-high), btn_n (raw active-low button), press (pulse on accepted 1->0)
module btn_debounce #(
  parameter int CYC = 500_000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_n,
  output logic press
);
  localparam int CW = $clog2(CYC + 1);
  logic s0, s1, lvl, acc;
  logic [CW-1:0] cnt;
  // cnt counts consecutive samples that differ from the accepted level
  assign acc = (s1 != lvl) && (cnt == CW'(CYC - 1));
  always_ff @(posedge clk) begin
    if (rst) begin
      s0 <= 1'b1;
      s1 <= 1'b1;
      lvl <= 1'b1;
      cnt <= '0;
      press <= 1'b0;
    end else begin
      s0 <= btn_n;
      s1 <= s0;
      cnt <= (s1 == lvl || acc) ? '0 : cnt + 1'b1;
      lvl <= acc ? s1 : lvl;
      press <= acc & ~s1;
    end
  end
endmodule

// File: rtl/board_debug_console.sv
// board_debug_console: RUN/HALT/STEP clock-enable controller with paged seven-segment result display
// Ports: clk, rst (sync, active-high), btn_mode_n/btn_step_n/btn_page_n (raw active-low buttons),
//   cpu_result (CPU word), cpu_ce (CPU enable pulse), mode_led {halted,running}, ledr (word LSBs),
//   hex (active-low digits, digit d at [7d+6:7d]).
// Build option LEADING_ZERO_BLANK_EN blanks digits above the page's most-significant non-zero nibble.
module board_debug_console
  import board_dbg_pkg::*;
#(
  parameter int DIV          = 25_000_000,
  parameter int DEBOUNCE_CYC = 500_000,
  parameter int NUM_DIGITS   = 2,
  parameter int LED_W        = 10
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    btn_mode_n,
  input  logic                    btn_step_n,
  input  logic                    btn_page_n,
  input  logic [31:0]             cpu_result,
  output logic                    cpu_ce,
  output logic [1:0]              mode_led,
  output logic [LED_W-1:0]        ledr,
  output logic [7*NUM_DIGITS-1:0] hex
);
  localparam int PAGES = pages(NUM_DIGITS);
  localparam int CW = $clog2(DIV);
`ifdef LEADING_ZERO_BLANK_EN
  localparam bit LZB = 1'b1;
`else
  localparam bit LZB = 1'b0;
`endif
  logic mode_p, step_p, page_p, tick, ce_d;
  logic [CW-1:0] cnt;
  logic [2:0] page;
  logic [31:0] word;
  logic [3:0] nib [NUM_DIGITS];
  logic [7*NUM_DIGITS-1:0] hex_nx;
  int msd;
  mode_t state;
  btn_debounce #(.CYC(DEBOUNCE_CYC)) u_mode (.clk(clk), .rst(rst), .btn_n(btn_mode_n), .press(mode_p));
  btn_debounce #(.CYC(DEBOUNCE_CYC)) u_step (.clk(clk), .rst(rst), .btn_n(btn_step_n), .press(step_p));
  btn_debounce #(.CYC(DEBOUNCE_CYC)) u_page (.clk(clk), .rst(rst), .btn_n(btn_page_n), .press(page_p));
  assign tick = cnt == CW'(DIV - 1);
  always_ff @(posedge clk) begin
    if (rst) cnt <= '0;
    else cnt <= tick ? '0 : cnt + 1'b1;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
      cpu_ce <= 1'b0;
      mode_led <= 2'b01;
    end else begin
      case (state)
        RUN: begin
          cpu_ce <= tick;
          if (mode_p) begin
            state <= HALT;
            mode_led <= 2'b10;
          end
        end
        HALT: begin
          cpu_ce <= !mode_p && step_p;
          if (mode_p) begin
            state <= RUN;
            mode_led <= 2'b01;
          end else if (step_p) state <= STEP;
        end
        default: begin
          cpu_ce <= 1'b0;
          state <= HALT;
        end
      endcase
    end
  end
  always_comb begin
    hex_nx = '0;
    msd = 0;
    nib = '{default: 4'h0};
    for (int d = 0; d < NUM_DIGITS; d++) begin
      nib[d] = (int'(page) * NUM_DIGITS + d < 8) ? 4'(word >> (4 * (int'(page) * NUM_DIGITS + d))) : 4'h0;
      if (nib[d] != 4'h0) msd = d;
    end
    for (int d = 0; d < NUM_DIGITS; d++)
      hex_nx[7*d +: 7] = ((int'(page) * NUM_DIGITS + d > 7) || (LZB && d > msd)) ? SEG_BLANK : hex_seg(nib[d]);
  end
  // word is taken one cycle after cpu_ce so it holds the CPU's post-update result
  always_ff @(posedge clk) begin
    if (rst) begin
      ce_d <= 1'b0;
      word <= '0;
      page <= '0;
      ledr <= '0;
      hex <= {NUM_DIGITS{hex_seg(4'h0)}};
    end else begin
      ce_d <= cpu_ce;
      word <= ce_d ? cpu_result : word;
      page <= page_p ? ((page == 3'(PAGES - 1)) ? 3'd0 : page + 3'd1) : page;
      ledr <= word[LED_W-1:0];
      hex <= hex_nx;
    end
  end
endmodule

// File: tb/tb_board_debug_console.sv
// tb_board_debug_console: directed self-checking bench for board_debug_console
module tb_board_debug_console;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [2:0] btn = 3'b111;
  logic [31:0] cpu_result = '0;
  logic cpu_ce;
  logic [1:0] mode_led;
  logic [9:0] ledr;
  logic [13:0] hex;
  int checks = 0, errors = 0;
  int cyc = 0, ce_cnt = 0, first = -1, phase_bad = 0;
  int c0, p0;
  logic seen;
  always #5 clk = ~clk;
  board_debug_console #(.DIV(4), .DEBOUNCE_CYC(3), .NUM_DIGITS(2), .LED_W(10)) dut (
    .clk(clk), .rst(rst), .btn_mode_n(btn[0]), .btn_step_n(btn[1]), .btn_page_n(btn[2]),
    .cpu_result(cpu_result), .cpu_ce(cpu_ce), .mode_led(mode_led), .ledr(ledr), .hex(hex)
  );
  always @(posedge clk) begin
    cyc++;
    if (rst) first = -1;
    else if (cpu_ce) begin
      ce_cnt++;
      if (first < 0) first = cyc;
      else if ((cyc - first) % 4 != 0) phase_bad++;
    end
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask
  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic press(input logic [2:0] mask);
    btn = ~mask;
    wait_cyc(10);
    btn = 3'b111;
    wait_cyc(10);
  endtask
  task automatic check_reset(input string tag);
    check({tag, "_ce"}, 32'(cpu_ce), 0);
    check({tag, "_mode"}, 32'(mode_led), 2'b01);
    check({tag, "_ledr"}, 32'(ledr), 0);
    check({tag, "_hex"}, 32'(hex), {7'h40, 7'h40});
  endtask
  initial begin
    wait_cyc(3);
    check_reset("rst");
    rst = 1'b0;
    cpu_result = 32'h0000_00A5;
    wait_cyc(4);
    c0 = ce_cnt;
    p0 = phase_bad;
    wait_cyc(16);
    check("run_ticks", 32'(ce_cnt - c0), 4);
    check("run_phase", 32'(phase_bad - p0), 0);
    check("a5_ledr", 32'(ledr), 10'h0A5);
    check("a5_hex", 32'(hex), {7'h08, 7'h12});
    press(3'b001);
    check("halt_mode", 32'(mode_led), 2'b10);
    c0 = ce_cnt;
    wait_cyc(40);
    check("halt_no_ce", 32'(ce_cnt - c0), 0);
    cpu_result = 32'h1234_5678;
    c0 = ce_cnt;
    press(3'b010);
    check("step_ce", 32'(ce_cnt - c0), 1);
    check("step_ledr", 32'(ledr), 10'h278);
    check("page0_hex", 32'(hex), {7'h78, 7'h00});
    press(3'b100);
    check("page1_hex", 32'(hex), {7'h12, 7'h02});
    press(3'b100);
    check("page2_hex", 32'(hex), {7'h30, 7'h19});
    press(3'b100);
    check("page3_hex", 32'(hex), {7'h79, 7'h24});
    press(3'b100);
    check("page_wrap_hex", 32'(hex), {7'h78, 7'h00});
    cpu_result = 32'h0000_CAFE;
    c0 = ce_cnt;
    foreach (btn[i]) begin end
    btn[1] = 1'b0; wait_cyc(1);
    btn[1] = 1'b1; wait_cyc(1);
    btn[1] = 1'b0; wait_cyc(1);
    btn[1] = 1'b1; wait_cyc(1);
    btn[1] = 1'b0; wait_cyc(10);
    btn[1] = 1'b1; wait_cyc(1);
    btn[1] = 1'b0; wait_cyc(1);
    btn[1] = 1'b1; wait_cyc(1);
    btn[1] = 1'b0; wait_cyc(1);
    btn[1] = 1'b1; wait_cyc(15);
    check("bounce_one_ce", 32'(ce_cnt - c0), 1);
    check("bounce_ledr", 32'(ledr), 10'h2FE);
    check("bounce_hex", 32'(hex), {7'h0E, 7'h06});
    p0 = phase_bad;
    press(3'b011);
    wait_cyc(20);
    check("sim_mode", 32'(mode_led), 2'b01);
    check("sim_phase", 32'(phase_bad - p0), 0);
    press(3'b001);
    check("halt2_mode", 32'(mode_led), 2'b10);
    btn = 3'b101;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = cpu_ce;
    end
    check("step_seen", 32'(seen), 1);
    rst = 1'b1;
    btn = 3'b111;
    wait_cyc(1);
    check_reset("rst_step");
    rst = 1'b0;
    wait_cyc(5);
    btn = 3'b110;
    wait_cyc(3);
    rst = 1'b1;
    btn = 3'b111;
    wait_cyc(2);
    check_reset("rst_deb");
    rst = 1'b0;
    wait_cyc(15);
    check("deb_dropped", 32'(mode_led), 2'b01);
    c0 = ce_cnt;
    wait_cyc(16);
    check("resume_ticks", 32'(ce_cnt - c0), 4);
`ifdef LEADING_ZERO_BLANK_EN
    press(3'b001);
    cpu_result = 32'h0000_0005;
    press(3'b010);
    check("lzb_hex", 32'(hex), {7'h7F, 7'h12});
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
